// File: rtl/display_bcm_decoder.sv
// display_bcm_decoder
// Binary-coded-modulation row driver for an LED panel. Each row is shifted
// out once per bit-plane (upstream re-presents the same pixels per plane),
// latched, then shown with oe high for basecycles<<plane cycles. After the
// last plane a one-cycle row_done pulse is emitted and plane wraps to 0.
// Every output except cpixel_ready is a registered copy of the next state.

module display_bcm_decoder #(
   parameter int segments   = 2,
   parameter int cyclewidth = 10,
   parameter int columns    = 64,
   parameter int basecycles = 1
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [segments*3*cyclewidth-1:0]    cpixel,
   input  logic                                cpixel_valid,
   output logic                                cpixel_ready,
   output logic [segments*3-1:0]               rgb,
   output logic                                rgb_valid,
   output logic                                lat,
   output logic                                oe,
   output logic [$clog2(cyclewidth)-1:0]       plane,
   output logic                                row_done
);

   localparam int planew = $clog2(cyclewidth);
   localparam int colw   = (columns > 1) ? $clog2(columns) : 1;
   // Must hold basecycles<<(cyclewidth-1) itself, hence the extra bit.
   localparam int cntw   = $clog2(basecycles << (cyclewidth - 1)) + 1;
   localparam int pixw   = segments * 3 * cyclewidth;

   localparam logic [colw-1:0]   last_col   = colw'(columns - 1);
   localparam logic [planew-1:0] last_plane = planew'(cyclewidth - 1);

   typedef enum logic [1:0] {
      SHIFT = 2'd0,
      FLUSH = 2'd1,
      LATCH = 2'd2,
      SHOW  = 2'd3
   } state_t;

   state_t              state_r, state_nxt_s;
   logic [planew-1:0]   plane_r, plane_nxt_s;
   logic [colw-1:0]     column_r, column_nxt_s;
   logic [cntw-1:0]     cnt_r, cnt_nxt_s;
   logic [segments*3-1:0] rgb_r, rgb_nxt_s;
   logic                rgb_valid_r, rgb_valid_nxt_s;
   logic                lat_r, lat_nxt_s;
   logic                oe_r, oe_nxt_s;
   logic                row_done_r, row_done_nxt_s;

   logic                accept_s;
   logic                show_end_s;
   logic [cntw-1:0]     cnt_load_s;

   // Pick bit p of every colour channel; segment field is {R,G,B}, MSB first,
   // and the output triplet is {r,g,b} in the same order.
   function automatic logic [segments*3-1:0] plane_bits(
      input logic [pixw-1:0]   pix,
      input logic [planew-1:0] p
   );
      logic [segments*3-1:0] bits;
      logic [cyclewidth-1:0] chan;
      bits = '0;
      for (int s = 0; s < segments; s++) begin
         for (int k = 0; k < 3; k++) begin
            chan = pix[s*3*cyclewidth + k*cyclewidth +: cyclewidth];
            bits[s*3 + k] = chan[p];
         end
      end
      return bits;
   endfunction

   assign cpixel_ready = (state_r == SHIFT);
   assign accept_s     = cpixel_valid & cpixel_ready;
   assign show_end_s   = (state_r == SHOW) && (cnt_r == '0);
   assign cnt_load_s   = (cntw'(basecycles) << plane_r) - cntw'(1);

   assign rgb       = rgb_r;
   assign rgb_valid = rgb_valid_r;
   assign lat       = lat_r;
   assign oe        = oe_r;
   assign plane     = plane_r;
   assign row_done  = row_done_r;

   // State register: FSM state, counters and all registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= SHIFT;
         plane_r     <= '0;
         column_r    <= '0;
         cnt_r       <= '0;
         rgb_r       <= '0;
         rgb_valid_r <= 1'b0;
         lat_r       <= 1'b0;
         oe_r        <= 1'b0;
         row_done_r  <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         plane_r     <= plane_nxt_s;
         column_r    <= column_nxt_s;
         cnt_r       <= cnt_nxt_s;
         rgb_r       <= rgb_nxt_s;
         rgb_valid_r <= rgb_valid_nxt_s;
         lat_r       <= lat_nxt_s;
         oe_r        <= oe_nxt_s;
         row_done_r  <= row_done_nxt_s;
      end
   end

   // Next-state logic: shift a row, flush the last strobe, latch, then show.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         SHIFT: begin
            if (accept_s && (column_r == last_col)) begin
               state_nxt_s = FLUSH;
            end else begin
               state_nxt_s = SHIFT;
            end
         end
         FLUSH:   state_nxt_s = LATCH;
         LATCH:   state_nxt_s = SHOW;
         SHOW: begin
            if (show_end_s) begin
               state_nxt_s = SHIFT;
            end else begin
               state_nxt_s = SHOW;
            end
         end
         default: state_nxt_s = SHIFT;
      endcase
   end

   // Output/datapath logic: next values of counters and registered outputs.
   always_comb begin
      column_nxt_s    = column_r;
      plane_nxt_s     = plane_r;
      cnt_nxt_s       = cnt_r;
      rgb_nxt_s       = rgb_r;
      rgb_valid_nxt_s = accept_s;

      if (accept_s) begin
         rgb_nxt_s = plane_bits(cpixel, plane_r);
         if (column_r == last_col) begin
            column_nxt_s = '0;
         end else begin
            column_nxt_s = column_r + colw'(1);
         end
      end else begin
         rgb_nxt_s    = rgb_r;
         column_nxt_s = column_r;
      end

      case (state_r)
         LATCH: cnt_nxt_s = cnt_load_s;
         SHOW: begin
            if (show_end_s) begin
               cnt_nxt_s = '0;
               if (plane_r == last_plane) begin
                  plane_nxt_s = '0;
               end else begin
                  plane_nxt_s = plane_r + planew'(1);
               end
            end else begin
               cnt_nxt_s = cnt_r - cntw'(1);
            end
         end
         default: cnt_nxt_s = cnt_r;
      endcase

      // lat and oe mirror the state being entered, so they are mutually exclusive.
      lat_nxt_s      = (state_nxt_s == LATCH);
      oe_nxt_s       = (state_nxt_s == SHOW);
      row_done_nxt_s = show_end_s && (plane_r == last_plane);
   end

endmodule

// File: tb/tb_display_bcm_decoder.sv
// Self-checking bench for display_bcm_decoder (segments=2, cyclewidth=10,
// columns=4, basecycles=2). A queue-based reference model predicts every
// cycle's outputs; table vectors and hand sequences cover the corner cases.

module tb_display_bcm_decoder;

   localparam int SEG  = 2;
   localparam int CW   = 10;
   localparam int COLS = 4;
   localparam int BC   = 2;

   logic        clk;
   logic        rst_n;
   logic [59:0] cpixel;
   logic        cpixel_valid;
   logic        cpixel_ready;
   logic [5:0]  rgb;
   logic        rgb_valid;
   logic        lat;
   logic        oe;
   logic [3:0]  plane;
   logic        row_done;

   display_bcm_decoder #(
      .segments(SEG), .cyclewidth(CW), .columns(COLS), .basecycles(BC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cpixel(cpixel), .cpixel_valid(cpixel_valid),
      .cpixel_ready(cpixel_ready), .rgb(rgb), .rgb_valid(rgb_valid),
      .lat(lat), .oe(oe), .plane(plane), .row_done(row_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       ready;
      logic       rgbv;
      logic       lat;
      logic       oe;
      logic       rd;
      logic [5:0] rgb;
      logic [3:0] plane;
   } rec_t;

   typedef struct {
      int          pl;
      logic [59:0] pix;
      logic [5:0]  rgb;
   } vec_t;

   int   checks   = 0;
   int   failures = 0;
   rec_t em;
   rec_t q[$];
   int   m_col;
   int   m_plane;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, expv, $time);
      end
   endtask

   // Bit p of each channel, straight from the field layout by shifting.
   function automatic logic [5:0] ref_bits(input logic [59:0] pix, input int p);
      logic [5:0]  r;
      logic [59:0] v;
      r = 6'd0;
      for (int s = 0; s < SEG; s++) begin
         for (int ch = 0; ch < 3; ch++) begin
            v = (pix >> (s*30 + (2-ch)*10)) & 60'h3ff;
            r[s*3 + 2 - ch] = v[p];
         end
      end
      return r;
   endfunction

   // Advance the model by one cycle given this cycle's inputs.
   task automatic model_step(input logic v, input logic [59:0] pix, input logic rn);
      rec_t nx;
      rec_t t;
      logic last;
      if (!rn) begin
         q.delete();
         m_col = 0;
         m_plane = 0;
         nx = '{ready: 1'b1, rgbv: 1'b0, lat: 1'b0, oe: 1'b0, rd: 1'b0, rgb: 6'd0, plane: 4'd0};
      end else begin
         if (q.size() > 0) begin
            nx = q.pop_front();
         end else begin
            nx = '{ready: 1'b1, rgbv: 1'b0, lat: 1'b0, oe: 1'b0, rd: 1'b0, rgb: 6'd0, plane: 4'(m_plane)};
         end
         nx.rgb  = em.rgb;
         nx.rgbv = 1'b0;
         if (em.ready && v) begin
            nx.rgbv = 1'b1;
            nx.rgb  = ref_bits(pix, m_plane);
            m_col++;
            if (m_col == COLS) begin
               m_col = 0;
               nx.ready = 1'b0;
               t = '{ready: 1'b0, rgbv: 1'b0, lat: 1'b1, oe: 1'b0, rd: 1'b0, rgb: 6'd0, plane: 4'(m_plane)};
               q.push_back(t);
               t.lat = 1'b0;
               t.oe  = 1'b1;
               for (int j = 0; j < (BC << m_plane); j++) q.push_back(t);
               last = (m_plane == CW - 1);
               m_plane = last ? 0 : m_plane + 1;
               t = '{ready: 1'b1, rgbv: 1'b0, lat: 1'b0, oe: 1'b0, rd: last, rgb: 6'd0, plane: 4'(m_plane)};
               q.push_back(t);
            end
         end
      end
      em = nx;
   endtask

   // One clock: drive inputs, predict, step the clock, compare everything.
   task automatic cyc(input logic v, input logic [59:0] pix, input logic rn);
      rst_n = rn;
      cpixel_valid = v;
      cpixel = pix;
      model_step(v, pix, rn);
      @(posedge clk);
      #1;
      chk("ready",     cpixel_ready, em.ready);
      chk("rgb_valid", rgb_valid,    em.rgbv);
      chk("rgb",       rgb,          em.rgb);
      chk("lat",       lat,          em.lat);
      chk("oe",        oe,           em.oe);
      chk("row_done",  row_done,     em.rd);
      chk("plane",     plane,        em.plane);
      chk("lat_oe_excl", lat & oe,   1'b0);
   endtask

   function automatic logic [59:0] rnd_pix();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return t[59:0];
   endfunction

   vec_t tbl[6];
   int   n;
   int   oecnt[CW];
   int   rgbv_cnt, lat_cnt, bad_lat, prev_lat, prev_oe;
   logic seen_rd;

   initial begin
      tbl[0] = '{0, {10'h000,10'h000,10'h000,10'h3ff,10'h3ff,10'h000}, 6'b000110};
      tbl[1] = '{3, {10'h000,10'h000,10'h000,10'h008,10'h000,10'h000}, 6'b000100};
      tbl[2] = '{3, {10'h000,10'h000,10'h000,10'h3f7,10'h000,10'h000}, 6'b000000};
      tbl[3] = '{3, {10'h3ff,10'h3ff,10'h3ff,10'h000,10'h000,10'h000}, 6'b111000};
      tbl[4] = '{0, {10'h000,10'h001,10'h000,10'h000,10'h000,10'h000}, 6'b010000};
      tbl[5] = '{9, {10'h000,10'h000,10'h000,10'h000,10'h000,10'h200}, 6'b000001};

      em = '{ready: 1'b1, rgbv: 1'b0, lat: 1'b0, oe: 1'b0, rd: 1'b0, rgb: 6'd0, plane: 4'd0};
      m_col = 0;
      m_plane = 0;
      rst_n = 1'b0;
      cpixel_valid = 1'b0;
      cpixel = 60'd0;

      // Reset held three cycles, valid pixels offered during it are ignored.
      for (int i = 0; i < 3; i++) cyc(1'b1, rnd_pix(), 1'b0);
      cyc(1'b0, 60'd0, 1'b1);
      chk("post_reset_ready", cpixel_ready, 1'b1);

      // Table vectors: reach the target plane, then present the vector pixel.
      for (int i = 0; i < 6; i++) begin
         cyc(1'b0, 60'd0, 1'b0);
         cyc(1'b0, 60'd0, 1'b1);
         n = 0;
         while (!(em.ready && (em.plane == 4'(tbl[i].pl))) && n < 4000) begin
            cyc(1'b1, 60'd0, 1'b1);
            n++;
         end
         chk("tbl_reach_plane", (n < 4000), 1'b1);
         cyc(1'b1, tbl[i].pix, 1'b1);
         chk("tbl_rgb", rgb, tbl[i].rgb);
         chk("tbl_rgb_valid", rgb_valid, 1'b1);
      end

      // Gap: three idle cycles mid-row, then the row completes after 4 accepts.
      cyc(1'b0, 60'd0, 1'b0);
      cyc(1'b0, 60'd0, 1'b1);
      cyc(1'b1, rnd_pix(), 1'b1);
      cyc(1'b1, rnd_pix(), 1'b1);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, rnd_pix(), 1'b1);
         chk("gap_no_rgb_valid", rgb_valid, 1'b0);
      end
      cyc(1'b1, rnd_pix(), 1'b1);
      chk("gap_third_ready", cpixel_ready, 1'b1);
      cyc(1'b1, rnd_pix(), 1'b1);
      chk("gap_flush_ready", cpixel_ready, 1'b0);
      chk("gap_flush_valid", rgb_valid, 1'b1);

      // Full row with continuous valid: oe lengths per plane, lat before each.
      cyc(1'b0, 60'd0, 1'b0);
      cyc(1'b0, 60'd0, 1'b1);
      for (int p = 0; p < CW; p++) oecnt[p] = 0;
      rgbv_cnt = 0; lat_cnt = 0; bad_lat = 0; prev_lat = 0; prev_oe = 0;
      seen_rd = 1'b0;
      n = 0;
      while (!seen_rd && n < 3000) begin
         cyc(1'b1, rnd_pix(), 1'b1);
         n++;
         if (oe) oecnt[plane]++;
         if (oe && !prev_oe && !prev_lat) bad_lat++;
         rgbv_cnt += int'(rgb_valid);
         lat_cnt  += int'(lat);
         prev_lat = int'(lat);
         prev_oe  = int'(oe);
         if (row_done) begin
            seen_rd = 1'b1;
            chk("row_done_plane0", plane, 4'd0);
            chk("row_done_ready", cpixel_ready, 1'b1);
         end
      end
      chk("row_done_seen", seen_rd, 1'b1);
      for (int p = 0; p < CW; p++) chk("oe_len", oecnt[p], BC << p);
      chk("rgbv_pulses", rgbv_cnt, CW * COLS);
      chk("lat_pulses", lat_cnt, CW);
      chk("lat_before_oe", bad_lat, 0);

      // Reset pulsed during SHOW drops oe on the next edge.
      n = 0;
      while (!oe && n < 200) begin
         cyc(1'b1, rnd_pix(), 1'b1);
         n++;
      end
      chk("reach_show", oe, 1'b1);
      cyc(1'b1, rnd_pix(), 1'b0);
      chk("rst_show_oe", oe, 1'b0);
      chk("rst_show_lat", lat, 1'b0);
      cyc(1'b0, 60'd0, 1'b1);

      // Randomized traffic with occasional resets, checked against the model.
      for (int i = 0; i < 8000; i++) begin
         cyc(($urandom_range(0, 3) != 0), rnd_pix(), ($urandom_range(0, 999) != 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
